// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified-memory port arbiter.
//   arb_state_e : transaction FSM states (IDLE, ISSUE, WAIT, RESP)
//   arb_owner_e : which requester owns the in-flight access
//   DEF_*       : default address/data widths and memory latency
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_MEM_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// arb_prio_sel: combinational fetch/data priority pick.
// Data requests win unless the starvation guard (macro ARB_STARVE_GUARD_EN)
// has counted STARVE_MAX consecutive data grants while a fetch was waiting.
// Ports:
//   clk_i, rst_i   clock / async active-high reset (guard build only)
//   arb_en_i       arbitration allowed this cycle
//   if_req_i       fetch request
//   dm_req_i       data request
//   if_gnt_o       fetch granted
//   dm_gnt_o       data granted
//   owner_o        owner of the granted request
module arb_prio_sel
  import mem_arb_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
  parameter int unsigned STARVE_MAX = 4
)
`endif
(
`ifdef ARB_STARVE_GUARD_EN
  input  logic       clk_i,
  input  logic       rst_i,
`endif
  input  logic       arb_en_i,
  input  logic       if_req_i,
  input  logic       dm_req_i,
  output logic       if_gnt_o,
  output logic       dm_gnt_o,
  output arb_owner_e owner_o
);

  logic force_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_if = (starve_q == SW'(STARVE_MAX));

  // Counts data grants made while a fetch is pending; saturates at the limit,
  // where the next contested arbitration goes to the fetch.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (dm_gnt_o && !force_if) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    if_gnt_o = 1'b0;
    dm_gnt_o = 1'b0;
    owner_o  = OWN_DM;
    if (arb_en_i) begin
      if (dm_req_i && !(force_if && if_req_i)) begin
        dm_gnt_o = 1'b1;
      end else if (if_req_i) begin
        if_gnt_o = 1'b1;
        owner_o  = OWN_IF;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the IF
// (fetch) and MEM (load/store) stages. One access in flight at a time:
// grant -> ISSUE (one mem_en cycle) -> WAIT (MEM_LAT cycles) -> RESP (rvalid
// pulse to the owner, new grant allowed in the same cycle).
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
// Ports:
//   clk_i, rst_i                        clock / async active-high reset
//   if_req_i, if_addr_i                 fetch request / address
//   if_gnt_o, if_rvalid_o, if_rdata_o   fetch grant / response pulse / data
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                          data request / store / addr / wdata
//   dm_gnt_o, dm_rvalid_o, dm_rdata_o   data grant / response pulse / load data
//   mem_en_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i            memory port
//   busy_o                              high whenever not IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_MAX = 4
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d, owner_sel;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              arb_en;
  logic              if_gnt, dm_gnt;
  logic              issue;

  // Grants are combinational, so they are also masked while reset is held.
  assign arb_en = ((state_q == IDLE) || (state_q == RESP)) && !rst_i;

  arb_prio_sel
`ifdef ARB_STARVE_GUARD_EN
  #(
    .STARVE_MAX (STARVE_MAX)
  )
`endif
  u_prio_sel (
`ifdef ARB_STARVE_GUARD_EN
    .clk_i    (clk_i),
    .rst_i    (rst_i),
`endif
    .arb_en_i (arb_en),
    .if_req_i (if_req_i),
    .dm_req_i (dm_req_i),
    .if_gnt_o (if_gnt),
    .dm_gnt_o (dm_gnt),
    .owner_o  (owner_sel)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (dm_gnt || if_gnt) begin
          state_d = ISSUE;
          owner_d = owner_sel;
          if (dm_gnt) begin
            we_d    = dm_we_i;
            addr_d  = dm_addr_i;
            wdata_d = dm_wdata_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata_i;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign issue       = (state_q == ISSUE);
  assign busy_o      = (state_q != IDLE);
  assign if_gnt_o    = if_gnt;
  assign dm_gnt_o    = dm_gnt;
  assign if_rvalid_o = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_rvalid_o = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = issue;
  assign mem_we_o    = issue && we_q;
  assign mem_addr_o  = issue ? addr_q : '0;
  assign mem_wdata_o = issue ? wdata_q : '0;

endmodule
